alu181_seq16: RTL and testbench
===============================

ALU181_SEQ16 -- requirements
Module: alu181_seq16

Interface
REQ-001 The block SHALL have parameter NIB, default 4, giving the number of 4-bit nibbles per operand (operand width W = 4*NIB).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  operation request, sampled at a rising edge while busy=0.
REQ-005 The block SHALL have port op_s  input  4  function select, passed unchanged to the ALU S inputs.
REQ-006 The block SHALL have port op_m  input  1  mode: 1=logic, 0=arithmetic.
REQ-007 The block SHALL have port cin  input  1  active-high carry into nibble 0.
REQ-008 The block SHALL have ports a, b  input  W  operands.
REQ-009 The block SHALL have port busy  output  1  operation in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port result  output  W  assembled F result.
REQ-012 The block SHALL have port cout  output  1  active-high carry out of the last nibble.
REQ-013 The block SHALL have port zero  output  1  result==0 flag (see Configuration).
REQ-014 The block SHALL have ALU-side outputs alu_a, alu_b, alu_s (4 bits each), alu_m (1 bit) and alu_cn_n (1 bit, active-low carry in).
REQ-015 The block SHALL have ALU-side inputs alu_f (4 bits) and alu_cout_n (1 bit, active-low carry out); the ALU is combinational between them.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE; busy SHALL equal (state==RUN).
REQ-017 At a rising edge with start=1 in IDLE or DONE, the block SHALL capture a, b, op_s, op_m and cin, clear idx, and enter RUN.
REQ-018 A start asserted while in RUN SHALL be ignored, with no effect on captured operands or results.
REQ-019 During RUN cycle i (i = 0..NIB-1), the block SHALL drive alu_a/alu_b with captured nibble i (LSB first), alu_s=op_s, alu_m=op_m, and alu_cn_n = ~carry_reg.
REQ-020 carry_reg SHALL be loaded with cin at capture; at the end of each RUN cycle it SHALL take ~alu_cout_n when op_m=0, and hold its value when op_m=1.
REQ-021 At the end of RUN cycle i, the block SHALL write alu_f into result[4i+3:4i].
REQ-022 After the edge that ends cycle NIB-1, the block SHALL enter DONE: done=1 for exactly one cycle, then IDLE (or RUN if start=1 in DONE).
REQ-023 Latency: start sampled at edge 0 SHALL produce done=1 between edges NIB and NIB+1.
REQ-024 result and cout SHALL hold their values from DONE until the next capture; cout SHALL equal the final carry_reg when op_m=0 and 0 when op_m=1.
REQ-025 Outside RUN, the block SHALL drive alu_a=alu_b=alu_s=0, alu_m=0 and alu_cn_n=1.
REQ-026 Arithmetic SHALL wrap modulo 2^W, with overflow reported only through cout.

Reset
REQ-027 While rst=1 the block SHALL immediately enter IDLE and drive busy=0, done=0, result=0, cout=0, zero=0, carry_reg=0 and idx=0, with ALU-side outputs per REQ-025.
REQ-028 A reset mid-RUN SHALL abort the operation with no done pulse; start SHALL be ignored until the first edge after rst deasserts.

Configuration
REQ-029 With macro ALU_SEQ_ZERO_FLAG_EN defined, zero SHALL be registered at the DONE transition as 1 iff all W result bits are 0.
REQ-030 Without ALU_SEQ_ZERO_FLAG_EN, zero SHALL be tied to 0 and no zero-detect logic SHALL be synthesised; all other behaviour SHALL be identical.

Verification (bench pairs the block with the team's 74LS181 model, NIB=4)
REQ-031 ADD: op_s=9, op_m=0, cin=0, a=0x1234, b=0x0FFF -> result=0x2233, cout=0, done at edge 4.
REQ-032 ADD with ripple: op_s=9, op_m=0, cin=0, a=0xFFFF, b=0x0001 -> result=0x0000, cout=1, zero=1 when the macro is defined.
REQ-033 SUB: op_s=6, op_m=0, cin=1, a=0x9000, b=0x0001 -> result=0x8FFF, cout=1.
REQ-034 XOR logic: op_s=6, op_m=1, a=0xF0F0, b=0xFF00 -> result=0x0FF0, cout=0; a second start pulsed during RUN -> ignored.
REQ-035 Reset abort: rst pulsed during RUN nibble 2 -> busy=0, result=0x0000, alu_cn_n=1, and no done pulse.
REQ-036 Back-to-back: start held through DONE -> new capture, with busy=1 on the following cycle and a new done 4 cycles later.

Source files
------------

// File: rtl/alu181_seq16.sv
// Nibble-serial sequencer for an external 74181-style ALU: feeds NIB nibbles LSB-first
// and assembles the W-bit result. Optional zero flag: define ALU_SEQ_ZERO_FLAG_EN.
module alu181_seq16 #(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op_s,
  input  logic               op_m,
  input  logic               cin,
  input  logic [4*NIB-1:0]   a,
  input  logic [4*NIB-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [4*NIB-1:0]   result,
  output logic               cout,
  output logic               zero,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [3:0]         alu_s,
  output logic               alu_m,
  output logic               alu_cn_n,
  input  logic [3:0]         alu_f,
  input  logic               alu_cout_n,
  output logic [1:0]         dbg_state
);
  // Handshake: a start seen at a rising edge while busy=0 (IDLE or DONE) is accepted;
  // start while busy=1 is dropped. done pulses for one cycle; result/cout then hold.
  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d, carry_q, carry_d, cout_q, cout_d;
  logic          capture, last;

  assign capture = start && (state_q != S_RUN);
  assign last    = (idx_q == IW'(NIB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_s     = 4'h0;
    alu_m     = 1'b0;
    alu_cn_n  = 1'b1;
    if (state_q == S_RUN) begin
      alu_a    = a_q[{idx_q, 2'b00} +: 4];
      alu_b    = b_q[{idx_q, 2'b00} +: 4];
      alu_s    = s_q;
      alu_m    = m_q;
      alu_cn_n = ~carry_q;
    end
  end

  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    if (capture) begin
      a_d     = a;
      b_d     = b;
      s_d     = op_s;
      m_d     = op_m;
      carry_d = cin;
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      result_d[{idx_q, 2'b00} +: 4] = alu_f;
      // Logic mode never ripples, so the carry chain is frozen.
      if (!m_q) carry_d = ~alu_cout_n;
      idx_d = last ? '0 : idx_q + 1'b1;
      if (last) cout_d = m_q ? 1'b0 : ~alu_cout_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 4'h0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if ((state_q == S_RUN) && last) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu181_seq16.sv
// Directed bench for alu181_seq16 (NIB=4) driving a behavioural 74181 on the ALU side.
module tb_alu181_seq16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_s = 4'h0;
  logic        op_m = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        busy, done, cout, zero;
  logic [15:0] result;
  logic [3:0]  alu_a, alu_b, alu_s, alu_f;
  logic        alu_m, alu_cn_n, alu_cout_n;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu181_seq16 #(.NIB(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_s(op_s), .op_m(op_m), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .cout(cout),
    .zero(zero), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_cn_n(alu_cn_n), .alu_f(alu_f), .alu_cout_n(alu_cout_n),
    .dbg_state(dbg_state)
  );

  // 74181, active-high data: F = X plus Y plus carry (arith), F = X xnor Y (logic).
  logic [3:0] x181, y181;
  logic [4:0] sum181;
  always_comb begin
    x181 = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    y181 = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    sum181 = {1'b0, x181} + {1'b0, y181} + {4'h0, ~alu_cn_n};
    alu_f = alu_m ? ~(x181 ^ y181) : sum181[3:0];
    alu_cout_n = ~sum181[4];
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    total++; if ({alu_a, alu_b, alu_s, alu_m, alu_cn_n} !== 14'b1) begin
      bad++; $display("FAIL reset_alu_side got=%h/%h/%h/%b/%b want=0/0/0/0/1", alu_a, alu_b, alu_s, alu_m, alu_cn_n);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                        input logic tm, input logic tc, input logic [15:0] er, input logic ec,
                        input logic ez, input logic poke, input string name);
    int cycles;
    logic ezv;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ezv = ez;
`else
    ezv = 1'b0;
`endif
    @(posedge clk); #1;
    a = ta; b = tb; op_s = ts; op_m = tm; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b want=1", name, busy); end
    total++; if ({alu_a, alu_b, alu_s, alu_m, alu_cn_n} !== {ta[3:0], tb[3:0], ts, tm, ~tc}) begin
      bad++; $display("FAIL %s_nib0 got=%h/%h/%h/%b/%b want=%h/%h/%h/%b/%b", name,
                      alu_a, alu_b, alu_s, alu_m, alu_cn_n, ta[3:0], tb[3:0], ts, tm, ~tc);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (poke && cycles == 1) begin start = 1'b1; a = 16'h5555; b = 16'hAAAA; end
      else start = 1'b0;
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        total++; if (alu_a !== ta[7:4] || alu_b !== tb[7:4]) begin
          bad++; $display("FAIL %s_nib1 got=%h/%h want=%h/%h", name, alu_a, alu_b, ta[7:4], tb[7:4]);
        end
      end
    end
    start = 1'b0;
    total++; if (cycles !== 4) begin bad++; $display("FAIL %s_latency got=%0d want=4", name, cycles); end
    total++; if (result !== er) begin bad++; $display("FAIL %s_result got=%h want=%h", name, result, er); end
    total++; if (cout !== ec) begin bad++; $display("FAIL %s_cout got=%b want=%b", name, cout, ec); end
    total++; if (zero !== ezv) begin bad++; $display("FAIL %s_zero got=%b want=%b", name, zero, ezv); end
    total++; if (busy !== 1'b0 || alu_cn_n !== 1'b1) begin
      bad++; $display("FAIL %s_done_state busy=%b cn_n=%b want 0/1", name, busy, alu_cn_n);
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%b want=0", name, done); end
    total++; if (result !== er || cout !== ec) begin
      bad++; $display("FAIL %s_hold got=%h/%b want=%h/%b", name, result, cout, er, ec);
    end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h0FFF; op_s = 4'h9; op_m = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (result !== 16'h0) begin bad++; $display("FAIL abort_result got=%h want=0000", result); end
    total++; if (alu_cn_n !== 1'b1) begin bad++; $display("FAIL abort_cn_n got=%b want=1", alu_cn_n); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen_done); end
  endtask

  task automatic test_back_to_back();
    int cycles;
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002; op_s = 4'h9; op_m = 1'b0; cin = 1'b0; start = 1'b1;
    cycles = 0;
    @(posedge clk); #1;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    total++; if (cycles !== 4) begin bad++; $display("FAIL b2b_lat1 got=%0d want=4", cycles); end
    total++; if (result !== 16'h0003 || cout !== 1'b0) begin
      bad++; $display("FAIL b2b_res1 got=%h/%b want=0003/0", result, cout);
    end
    a = 16'h0100; b = 16'h0000; op_s = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0 || alu_a !== 4'h0 || alu_s !== 4'hF) begin
      bad++; $display("FAIL b2b_recapture busy=%b done=%b alu_a=%h alu_s=%h want 1/0/0/f", busy, done, alu_a, alu_s);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    total++; if (cycles !== 4) begin bad++; $display("FAIL b2b_lat2 got=%0d want=4", cycles); end
    total++; if (result !== 16'h00FF || cout !== 1'b1) begin
      bad++; $display("FAIL b2b_res2 got=%h/%b want=00ff/1", result, cout);
    end
  endtask

  initial begin
    test_reset();
    run_op(16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, "add");
    run_op(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, "add_ripple");
    run_op(16'h9000, 16'h0001, 4'h6, 1'b0, 1'b1, 16'h8FFF, 1'b1, 1'b0, 1'b0, "sub");
    run_op(16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b1, "xor");
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
